// File: rtl/mac_accum_pipe_pkg.sv
// Shared widths and FSM state type for the mac_accum_pipe block.
package SysVerParam;
    localparam int SYS_P     = 8;
    localparam int SYS_ACC_W = 2 * SYS_P + 4;
    localparam int SYS_CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;
endpackage

// File: rtl/mac_accum_pipe_mul_reg.sv
// Front end of mac_accum_pipe: S1 input capture and S2 registered product.
module mac_mul_reg
#(
    parameter int P = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [P-1:0]     a,
    input  logic [P-1:0]     b,
    input  logic [P-1:0]     c,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             mode,
    output logic [2*P-1:0]   prod_p2,
    output logic [P-1:0]     bias_p2,
    output logic             last_p2,
    output logic             mode_p2,
    output logic             vld_p2
);
    logic [P-1:0] a_p1;
    logic [P-1:0] b_p1;
    logic [P-1:0] c_p1;
    logic         last_p1;
    logic         mode_p1;
    logic         vld_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            vld_p2 <= vld_p1;
        end
    end

    // S1: operands only move when strobed, so idle bus activity is ignored
    always_ff @(posedge clk) begin
        if (in_valid) begin
            a_p1    <= a;
            b_p1    <= b;
            c_p1    <= c;
            last_p1 <= in_last;
            mode_p1 <= mode;
        end
    end

    // S2: registered full-width product
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            prod_p2 <= (2*P)'(a_p1) * (2*P)'(b_p1);
            bias_p2 <= c_p1;
            last_p2 <= last_p1;
            mode_p2 <= mode_p1;
        end
    end
endmodule

// File: rtl/mac_accum_pipe.sv
// Three-stage unsigned MAC with single-sample and frame-accumulate modes.
// Build option MAC_SAT_EN: accumulator clamps on carry-out and OVF flags the frame.
module mac_accum_pipe
    import SysVerParam::*;
#(
    parameter int P     = SYS_P,
    parameter int ACC_W = 2 * P + 4,
    parameter int CNT_W = SYS_CNT_W
)(
    input  logic             C,
    input  logic             RST,
    input  logic [P-1:0]     A1,
    input  logic [P-1:0]     B1,
    input  logic [P-1:0]     C1,
    input  logic             IN_VALID,
    input  logic             IN_LAST,
    input  logic             MODE,
    output logic [ACC_W-1:0] DATA_OUT,
    output logic             OUT_VALID,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF
);
    logic [2*P-1:0]   prod_p2;
    logic [P-1:0]     bias_p2;
    logic             last_p2;
    logic             mode_p2;
    logic             vld_p2;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             add;
    logic             emit;
    logic [ACC_W-1:0] mac_p2;
    logic [ACC_W-1:0] acc_p3;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_p3;
    logic [CNT_W-1:0] cnt_nxt;

    mac_mul_reg #(.P(P)) u_mul (
        .clk      (C),
        .rst      (RST),
        .a        (A1),
        .b        (B1),
        .c        (C1),
        .in_valid (IN_VALID),
        .in_last  (IN_LAST),
        .mode     (MODE),
        .prod_p2  (prod_p2),
        .bias_p2  (bias_p2),
        .last_p2  (last_p2),
        .mode_p2  (mode_p2),
        .vld_p2   (vld_p2)
    );

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef MAC_SAT_EN
    logic sat_p3;
    logic sat_nxt;
    logic ovf_p3;

    // Returns {clamped, value}; once clamped the frame stays at full scale.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] x,
                                               input logic [ACC_W-1:0] y,
                                               input logic             clamped);
        logic [ACC_W:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        if (clamped || sum[ACC_W])
            return {1'b1, {ACC_W{1'b1}}};
        return sum;
    endfunction
`else
    function automatic logic [ACC_W-1:0] wrap_add(input logic [ACC_W-1:0] x,
                                                  input logic [ACC_W-1:0] y);
        return x + y;
    endfunction
`endif

    always_ff @(posedge C or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Mode is only looked at in IDLE, so it is effectively latched per frame
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vld_p2 && mode_p2 && !last_p2) state_nxt = ACCUM;
            ACCUM:   if (vld_p2 && last_p2)             state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load = 1'b0;
        add  = 1'b0;
        emit = 1'b0;
        case (state)
            IDLE: begin
                load = vld_p2;
                emit = vld_p2 && (!mode_p2 || last_p2);
            end
            ACCUM: begin
                add  = vld_p2;
                emit = vld_p2 && last_p2;
            end
            default: ;
        endcase
    end

    always_comb begin
        mac_p2  = ACC_W'(prod_p2) + ACC_W'(bias_p2);
        acc_nxt = acc_p3;
        cnt_nxt = cnt_p3;
`ifdef MAC_SAT_EN
        sat_nxt = sat_p3;
`endif
        if (load) begin
            acc_nxt = mac_p2;
            cnt_nxt = CNT_W'(1);
`ifdef MAC_SAT_EN
            sat_nxt = 1'b0;
`endif
        end else if (add) begin
`ifdef MAC_SAT_EN
            {sat_nxt, acc_nxt} = sat_add(acc_p3, ACC_W'(prod_p2), sat_p3);
`else
            acc_nxt = wrap_add(acc_p3, ACC_W'(prod_p2));
`endif
            cnt_nxt = cnt_inc(cnt_p3);
        end
    end

    // S3: accumulator and output registers
    always_ff @(posedge C or posedge RST) begin
        if (RST) begin
            acc_p3    <= '0;
            cnt_p3    <= '0;
            DATA_OUT  <= '0;
            COUNT     <= '0;
            OUT_VALID <= 1'b0;
`ifdef MAC_SAT_EN
            sat_p3    <= 1'b0;
            ovf_p3    <= 1'b0;
`endif
        end else begin
            acc_p3    <= acc_nxt;
            cnt_p3    <= cnt_nxt;
            OUT_VALID <= emit;
`ifdef MAC_SAT_EN
            sat_p3    <= sat_nxt;
`endif
            if (emit) begin
                DATA_OUT <= acc_nxt;
                COUNT    <= cnt_nxt;
`ifdef MAC_SAT_EN
                ovf_p3   <= sat_nxt;
`endif
            end
        end
    end

`ifdef MAC_SAT_EN
    assign OVF = ovf_p3;
`else
    assign OVF = 1'b0;
`endif
endmodule

// File: tb/tb_mac_accum_pipe.sv
// Directed self-checking bench for mac_accum_pipe (P=8, ACC_W=20, CNT_W=8).
`timescale 1ns/1ps
module tb_mac_accum_pipe;
    localparam int P     = 8;
    localparam int ACC_W = 20;
    localparam int CNT_W = 8;

    logic             C = 1'b0;
    logic             RST = 1'b1;
    logic [P-1:0]     A1 = '0;
    logic [P-1:0]     B1 = '0;
    logic [P-1:0]     C1 = '0;
    logic             IN_VALID = 1'b0;
    logic             IN_LAST = 1'b0;
    logic             MODE = 1'b0;
    logic [ACC_W-1:0] DATA_OUT;
    logic             OUT_VALID;
    logic [CNT_W-1:0] COUNT;
    logic             OVF;

    mac_accum_pipe #(.P(P), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .C         (C),
        .RST       (RST),
        .A1        (A1),
        .B1        (B1),
        .C1        (C1),
        .IN_VALID  (IN_VALID),
        .IN_LAST   (IN_LAST),
        .MODE      (MODE),
        .DATA_OUT  (DATA_OUT),
        .OUT_VALID (OUT_VALID),
        .COUNT     (COUNT),
        .OVF       (OVF)
    );

    always #5 C = ~C;

    int cyc = 0;
    always @(posedge C) cyc <= cyc + 1;

    typedef struct {
        logic [ACC_W-1:0] data;
        logic [CNT_W-1:0] count;
        logic             ovf;
        int               at;
    } emit_t;
    emit_t em_q[$];

    always @(negedge C)
        if (OUT_VALID) em_q.push_back('{DATA_OUT, COUNT, OVF, cyc});

    typedef struct {
        logic [P-1:0]     a;
        logic [P-1:0]     b;
        logic [P-1:0]     c;
        logic [ACC_W-1:0] exp;
    } vec_t;
    vec_t vecs[6];

    int checks   = 0;
    int failures = 0;
    int last_cyc = 0;
    int app[16];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1ns after an edge; the sample is captured on the following edge.
    task automatic send(input int a, input int b, input int c, input logic m, input logic l);
        IN_VALID = 1'b1;
        A1 = P'(a);
        B1 = P'(b);
        C1 = P'(c);
        MODE = m;
        IN_LAST = l;
        last_cyc = cyc;
        @(posedge C);
        #1;
    endtask

    task automatic idle(input int n);
        IN_VALID = 1'b0;
        A1 = 8'hA5;
        B1 = 8'h5A;
        C1 = 8'h33;
        IN_LAST = 1'b1;
        repeat (n) begin
            @(posedge C);
            #1;
        end
    endtask

    task automatic check_emit(input string name, input int idx, input longint data,
                              input longint count, input longint ovf, input int at);
        if (em_q.size() > idx) begin
            check({name, "_data"},  em_q[idx].data,  data);
            check({name, "_count"}, em_q[idx].count, count);
            check({name, "_ovf"},   em_q[idx].ovf,   ovf);
            check({name, "_cycle"}, em_q[idx].at,    at);
        end else begin
            check({name, "_present"}, 0, 1);
        end
    endtask

    initial begin
        vecs[0] = '{8'd3,   8'd4,   8'd5,   20'd17};
        vecs[1] = '{8'd0,   8'd0,   8'd0,   20'd0};
        vecs[2] = '{8'd255, 8'd255, 8'd255, 20'd65280};
        vecs[3] = '{8'd1,   8'd0,   8'd7,   20'd7};
        vecs[4] = '{8'd16,  8'd16,  8'd0,   20'd256};
        vecs[5] = '{8'd255, 8'd1,   8'd0,   20'd255};

        repeat (2) @(posedge C);
        #1;
        check("rst_data",  DATA_OUT,  0);
        check("rst_count", COUNT,     0);
        check("rst_ovf",   OVF,       0);
        check("rst_valid", OUT_VALID, 0);
        RST = 1'b0;
        idle(2);

        // mode 0 table, back to back, IN_LAST toggled (ignored)
        em_q.delete();
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, i[0]);
            app[i] = last_cyc;
        end
        idle(6);
        check("m0_emits", em_q.size(), 6);
        for (int i = 0; i < 6; i++)
            check_emit($sformatf("m0_vec%0d", i), i, vecs[i].exp, 1, 0, app[i] + 3);

        // frame accumulate, back to back; C1 ignored after first sample
        em_q.delete();
        send(2, 3, 10, 1'b1, 1'b0);
        send(4, 5, 99, 1'b1, 1'b0);
        send(1, 1, 0,  1'b1, 1'b1);
        idle(6);
        check("f_b2b_emits", em_q.size(), 1);
        check_emit("f_b2b", 0, 37, 3, 0, last_cyc + 3);
        check("f_hold_data", DATA_OUT, 37);
        check("f_hold_valid", OUT_VALID, 0);

        // same frame with two-cycle gaps
        em_q.delete();
        send(2, 3, 10, 1'b1, 1'b0);
        idle(2);
        send(4, 5, 0, 1'b1, 1'b0);
        idle(2);
        send(1, 1, 0, 1'b1, 1'b1);
        idle(6);
        check("f_gap_emits", em_q.size(), 1);
        check_emit("f_gap", 0, 37, 3, 0, last_cyc + 3);

        // MODE dropped mid-frame is ignored
        em_q.delete();
        send(2, 3, 10, 1'b1, 1'b0);
        send(4, 5, 7,  1'b0, 1'b0);
        send(1, 1, 0,  1'b0, 1'b1);
        idle(6);
        check("f_mode_emits", em_q.size(), 1);
        check_emit("f_mode", 0, 37, 3, 0, last_cyc + 3);

        // frames and a mode-0 sample with no bubbles between them
        em_q.delete();
        send(2, 2, 1,  1'b1, 1'b0);
        send(3, 3, 50, 1'b1, 1'b1);
        app[0] = last_cyc;
        send(5, 5, 2,  1'b1, 1'b1);
        app[1] = last_cyc;
        send(1, 1, 1,  1'b0, 1'b0);
        app[2] = last_cyc;
        idle(6);
        check("nb_emits", em_q.size(), 3);
        check_emit("nb_f1", 0, 14, 2, 0, app[0] + 3);
        check_emit("nb_f2", 1, 27, 1, 0, app[1] + 3);
        check_emit("nb_m0", 2, 2,  1, 0, app[2] + 3);

        // accumulator range boundary: 17 * 65025
        em_q.delete();
        for (int i = 0; i < 17; i++)
            send(255, 255, 0, 1'b1, i == 16);
        idle(6);
        check("big_emits", em_q.size(), 1);
`ifdef MAC_SAT_EN
        check_emit("big", 0, 1048575, 17, 1, last_cyc + 3);
`else
        check_emit("big", 0, 56849, 17, 0, last_cyc + 3);
`endif

        // following frame starts clean
        em_q.delete();
        send(1, 1, 1, 1'b0, 1'b0);
        idle(6);
        check_emit("post_big", 0, 2, 1, 0, last_cyc + 3);

        // COUNT saturation over a 300-sample frame
        em_q.delete();
        for (int i = 0; i < 300; i++)
            send(1, 1, 0, 1'b1, i == 299);
        idle(6);
        check("cnt_emits", em_q.size(), 1);
        check_emit("cnt_sat", 0, 300, 255, 0, last_cyc + 3);

        // reset mid-frame discards the partial frame
        em_q.delete();
        send(1, 2, 3, 1'b1, 1'b0);
        send(4, 5, 6, 1'b1, 1'b0);
        IN_VALID = 1'b0;
        RST = 1'b1;
        #2;
        check("mid_rst_data",  DATA_OUT,  0);
        check("mid_rst_count", COUNT,     0);
        check("mid_rst_valid", OUT_VALID, 0);
        @(posedge C);
        #1;
        RST = 1'b0;
        idle(6);
        check("mid_rst_no_emit", em_q.size(), 0);
        send(1, 1, 0, 1'b1, 1'b1);
        idle(6);
        check("post_rst_emits", em_q.size(), 1);
        check_emit("post_rst", 0, 1, 1, 0, last_cyc + 3);

        // mode 0 throughput: one result per cycle
        em_q.delete();
        for (int i = 0; i < 8; i++) begin
            send(i, 2, 1, 1'b0, 1'b0);
            app[i] = last_cyc;
        end
        idle(6);
        check("tput_emits", em_q.size(), 8);
        for (int i = 0; i < 8; i++)
            check_emit($sformatf("tput%0d", i), i, 2 * i + 1, 1, 0, app[i] + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end
endmodule
